// File: rtl/twiddle_pkg.sv
// rtl/twiddle_pkg.sv - shared types and elaboration-time ROM helper for the twiddle streamer
package twiddle_pkg;

   typedef enum logic {ST_IDLE, ST_RUN} state_t;

   // round(FS*cos(2*pi*r/N)) via a Taylor series, evaluated only at elaboration
   function automatic int gen_quarter_cos(input int log2n, input int w, input int r);
      real fs;
      real x;
      real term;
      real sum;
      fs   = real'((longint'(1) << (w - 1)) - 1);
      x    = 2.0 * 3.14159265358979323846 * real'(r) / real'(longint'(1) << log2n);
      term = 1.0;
      sum  = 1.0;
      for (int n = 1; n <= 14; n++) begin
         term = -term * x * x / real'((2 * n - 1) * (2 * n));
         sum  = sum + term;
      end
      return $rtoi(fs * sum + 0.5);
   endfunction

endpackage

// File: rtl/twiddle_stream_gen_qlut.sv
// rtl/twiddle_stream_gen_qlut.sv - quarter-wave cosine ROM with PARL sync read ports and quadrant fold
module twiddle_stream_gen_qlut
   import twiddle_pkg::*;
#(
   parameter int LOG2N = 8,
   parameter int PARL  = 1,
   parameter int W     = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         rd_en,
   input  logic [PARL-1:0][LOG2N-1:0]   e_i,
   output logic [PARL-1:0][W-1:0]       cos_f,
   output logic [PARL-1:0][W-1:0]       sin_f
);

   localparam int Q  = 1 << (LOG2N - 2);
   localparam int AW = LOG2N - 1;

   logic [W-1:0] rom [Q+1];

   for (genvar r = 0; r <= Q; r++) begin : g_rom
      localparam logic [W-1:0] TV = W'(gen_quarter_cos(LOG2N, W, r));
      assign rom[r] = TV;
   end

   logic [PARL-1:0][W-1:0] ta_q, ta_d;
   logic [PARL-1:0][W-1:0] tb_q, tb_d;
   logic [PARL-1:0][1:0]   quad_q, quad_d;
   logic [AW-1:0]          ra;

   // address both table entries per lane; hold when the downstream stage stalls
   always_comb begin
      ta_d   = ta_q;
      tb_d   = tb_q;
      quad_d = quad_q;
      ra     = '0;
      if (rd_en) begin
         for (int p = 0; p < PARL; p++) begin
            ra        = {1'b0, e_i[p][LOG2N-3:0]};
            ta_d[p]   = rom[ra];
            tb_d[p]   = rom[AW'(Q) - ra];
            quad_d[p] = e_i[p][LOG2N-1:LOG2N-2];
         end
      end
   end

   // registered ROM read data
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ta_q   <= '0;
         tb_q   <= '0;
         quad_q <= '0;
      end else begin
         ta_q   <= ta_d;
         tb_q   <= tb_d;
         quad_q <= quad_d;
      end
   end

   // fold the first-quadrant values into the quadrant selected by e's top bits
   always_comb begin
      cos_f = '0;
      sin_f = '0;
      for (int p = 0; p < PARL; p++) begin
         case (quad_q[p])
            2'd0: begin cos_f[p] = ta_q[p];  sin_f[p] = tb_q[p];  end
            2'd1: begin cos_f[p] = -tb_q[p]; sin_f[p] = ta_q[p];  end
            2'd2: begin cos_f[p] = -ta_q[p]; sin_f[p] = -tb_q[p]; end
            default: begin cos_f[p] = tb_q[p]; sin_f[p] = -ta_q[p]; end
         endcase
      end
   end

endmodule

// File: rtl/twiddle_stream_gen.sv
// rtl/twiddle_stream_gen.sv - per-stage twiddle streamer: FSM, beat counter, elastic 3-stage pipe
module twiddle_stream_gen
   import twiddle_pkg::*;
#(
   parameter int LOG2N = 8,
   parameter int PARL  = 1,
   parameter int W     = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic [$clog2(LOG2N):0]    stage,
   input  logic                      inv,
   output logic                      busy,
   output logic                      tvalid,
   input  logic                      tready,
   output logic                      tlast,
   output logic [PARL-1:0][W-1:0]    cos_o,
   output logic [PARL-1:0][W-1:0]    sin_o
);

   localparam int SW     = $clog2(LOG2N) + 1;
   localparam int NBEATS = (1 << (LOG2N - 1)) / PARL;
   localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
   localparam int PW     = $clog2(PARL);
   localparam logic [LOG2N-1:0] ONE_E = 1;

   state_t                     state_q, state_d;
   logic [SW-1:0]              stage_q, stage_d;
   logic                       inv_q, inv_d;
   logic [BW-1:0]              beat_q, beat_d;
   logic                       issued_q, issued_d;
   logic                       v1_q, v1_d, last1_q, last1_d;
   logic [PARL-1:0][LOG2N-1:0] e1_q, e1_d;
   logic                       v2_q, v2_d, last2_q, last2_d;
   logic                       v3_q, v3_d, last3_q, last3_d;
   logic [PARL-1:0][W-1:0]     cos_q, cos_d, sin_q, sin_d;
   logic [PARL-1:0][W-1:0]     cos_f, sin_f;
   logic                       adv1, adv2, adv3, issue, start_ok, last_beat;

   // exponent e for lane p of beat b at stage s: (j mod 2^(s-1)) << (LOG2N-s)
   function automatic logic [LOG2N-1:0] lane_e(input logic [BW-1:0] b, input int p,
                                                input logic [SW-1:0] s);
      logic [LOG2N-1:0] j;
      logic [LOG2N-1:0] mask;
      j    = (LOG2N'(b) << PW) | LOG2N'(p);
      mask = (ONE_E << (s - SW'(1))) - ONE_E;
      return (j & mask) << (LOG2N - int'(s));
   endfunction

   // handshake-driven advance: a stage moves when its output is empty or is being taken
   always_comb begin
      adv3      = !v3_q || tready;
      adv2      = !v2_q || adv3;
      adv1      = !v1_q || adv2;
      last_beat = (beat_q == BW'(NBEATS - 1));
      start_ok  = start && (state_q == ST_IDLE) && (stage != '0) && (stage <= SW'(LOG2N));
      issue     = (state_q == ST_RUN) && !issued_q && adv1;
   end

   // frame FSM and beat counter
   always_comb begin
      state_d  = state_q;
      stage_d  = stage_q;
      inv_d    = inv_q;
      beat_d   = beat_q;
      issued_d = issued_q;
      case (state_q)
         ST_IDLE: begin
            if (start_ok) begin
               state_d  = ST_RUN;
               stage_d  = stage;
               inv_d    = inv;
               beat_d   = '0;
               issued_d = 1'b0;
            end
         end
         default: begin
            if (issue) begin
               beat_d = beat_q + BW'(1);
               if (last_beat) issued_d = 1'b1;
            end
            if (v3_q && tready && last3_q) state_d = ST_IDLE;
         end
      endcase
   end

   // pipe stage contents: index gen, ROM read (inside qlut), fold/negate output
   always_comb begin
      v1_d    = v1_q;
      last1_d = last1_q;
      e1_d    = e1_q;
      v2_d    = v2_q;
      last2_d = last2_q;
      v3_d    = v3_q;
      last3_d = last3_q;
      cos_d   = cos_q;
      sin_d   = sin_q;
      if (adv1) begin
         v1_d    = issue;
         last1_d = issue && last_beat;
         for (int p = 0; p < PARL; p++) e1_d[p] = lane_e(beat_q, p, stage_q);
      end
      if (adv2) begin
         v2_d    = v1_q;
         last2_d = last1_q;
      end
      if (adv3) begin
         v3_d    = v2_q;
         last3_d = last2_q;
         for (int p = 0; p < PARL; p++) begin
            cos_d[p] = cos_f[p];
            sin_d[p] = inv_q ? sin_f[p] : -sin_f[p];
         end
      end
   end

   // all state registers; reset discards any partial frame
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         stage_q  <= '0;
         inv_q    <= 1'b0;
         beat_q   <= '0;
         issued_q <= 1'b0;
         v1_q     <= 1'b0;
         last1_q  <= 1'b0;
         e1_q     <= '0;
         v2_q     <= 1'b0;
         last2_q  <= 1'b0;
         v3_q     <= 1'b0;
         last3_q  <= 1'b0;
         cos_q    <= '0;
         sin_q    <= '0;
      end else begin
         state_q  <= state_d;
         stage_q  <= stage_d;
         inv_q    <= inv_d;
         beat_q   <= beat_d;
         issued_q <= issued_d;
         v1_q     <= v1_d;
         last1_q  <= last1_d;
         e1_q     <= e1_d;
         v2_q     <= v2_d;
         last2_q  <= last2_d;
         v3_q     <= v3_d;
         last3_q  <= last3_d;
         cos_q    <= cos_d;
         sin_q    <= sin_d;
      end
   end

   twiddle_stream_gen_qlut #(.LOG2N(LOG2N), .PARL(PARL), .W(W)) u_qlut (
      .clk   (clk),
      .rst_n (rst_n),
      .rd_en (adv2),
      .e_i   (e1_q),
      .cos_f (cos_f),
      .sin_f (sin_f)
   );

   assign busy   = (state_q == ST_RUN);
   assign tvalid = v3_q;
   assign tlast  = last3_q;
   assign cos_o  = cos_q;
   assign sin_o  = sin_q;

endmodule

// File: tb/tb_twiddle_stream_gen.sv
// tb/tb_twiddle_stream_gen.sv - scoreboard bench for twiddle_stream_gen at N=16, PARL=1 and PARL=4
module tb_twiddle_stream_gen;

   localparam real PI = 3.14159265358979323846;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic             start1, inv1, tready1, busy1, tvalid1, tlast1;
   logic [2:0]       stage1;
   logic [0:0][15:0] cos1, sin1;
   logic             start4, inv4, tready4, busy4, tvalid4, tlast4;
   logic [2:0]       stage4;
   logic [3:0][15:0] cos4, sin4;

   twiddle_stream_gen #(.LOG2N(4), .PARL(1), .W(16)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .stage(stage1), .inv(inv1), .busy(busy1),
      .tvalid(tvalid1), .tready(tready1), .tlast(tlast1), .cos_o(cos1), .sin_o(sin1));

   twiddle_stream_gen #(.LOG2N(4), .PARL(4), .W(16)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .stage(stage4), .inv(inv4), .busy(busy4),
      .tvalid(tvalid4), .tready(tready4), .tlast(tlast4), .cos_o(cos4), .sin_o(sin4));

   typedef struct packed {
      logic             last;
      logic [3:0][15:0] c;
      logic [3:0][15:0] s;
   } beat_t;

   beat_t q1[$];
   beat_t q4[$];
   int    checks = 0;
   int    failures = 0;
   int    cyc = 0;
   bit    rnd = 0;
   int    first_cyc[2];
   int    last_cyc[2];
   int    start_cyc[2];
   bit    stalled[2];
   bit    after_last[2];
   beat_t held[2];

   task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] fx(input real y);
      int v;
      if (y >= 0.0) v = $rtoi(y + 0.5);
      else          v = -$rtoi(-y + 0.5);
      return v[15:0];
   endfunction

   task automatic push_frame(input int sel, input int s, input bit inv);
      int    pl, nb, j, k, e;
      real   th;
      beat_t bt;
      pl = (sel != 0) ? 4 : 1;
      nb = 8 / pl;
      for (int b = 0; b < nb; b++) begin
         bt = '0;
         for (int p = 0; p < pl; p++) begin
            j  = b * pl + p;
            k  = j % (1 << (s - 1));
            e  = k << (4 - s);
            th = 2.0 * PI * real'(e) / 16.0;
            bt.c[p] = fx(32767.0 * $cos(th));
            bt.s[p] = inv ? fx(32767.0 * $sin(th)) : fx(-32767.0 * $sin(th));
         end
         bt.last = (b == nb - 1);
         if (sel != 0) q4.push_back(bt);
         else          q1.push_back(bt);
      end
   endtask

   task automatic sample(input int sel);
      beat_t obs, ex;
      bit    tv, tr, bs;
      int    pl;
      obs = '0;
      pl  = (sel != 0) ? 4 : 1;
      if (sel == 0) begin
         tv = tvalid1; tr = tready1; bs = busy1;
         obs.last = tlast1; obs.c[0] = cos1[0]; obs.s[0] = sin1[0];
      end else begin
         tv = tvalid4; tr = tready4; bs = busy4;
         obs.last = tlast4; obs.c = cos4; obs.s = sin4;
      end
      if (after_last[sel]) begin
         check($sformatf("d%0d_busy_after_last", sel), bs, 0);
         after_last[sel] = 0;
      end
      if (stalled[sel]) begin
         check($sformatf("d%0d_hold_valid", sel), tv, 1);
         check($sformatf("d%0d_hold_data", sel), obs, held[sel]);
      end
      if (tv && first_cyc[sel] < 0) first_cyc[sel] = cyc;
      if (tv && tr) begin
         if ((sel == 0 && q1.size() == 0) || (sel != 0 && q4.size() == 0)) begin
            check($sformatf("d%0d_extra_beat", sel), 1, 0);
         end else begin
            ex = (sel != 0) ? q4.pop_front() : q1.pop_front();
            for (int p = 0; p < pl; p++) begin
               check($sformatf("d%0d_cos_l%0d", sel, p), obs.c[p], ex.c[p]);
               check($sformatf("d%0d_sin_l%0d", sel, p), obs.s[p], ex.s[p]);
            end
            check($sformatf("d%0d_tlast", sel), obs.last, ex.last);
            if (obs.last) begin
               after_last[sel] = 1;
               last_cyc[sel]   = cyc;
            end
         end
      end
      stalled[sel] = tv && !tr;
      held[sel]    = obs;
   endtask

   task automatic tick();
      tready1 = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tready4 = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #3;
      sample(0);
      sample(1);
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic start_frame(input int sel, input int s, input bit inv, input bit accept);
      if (accept) begin
         push_frame(sel, s, inv);
         first_cyc[sel] = -1;
      end
      if (sel == 0) begin start1 = 1; stage1 = 3'(s); inv1 = inv; end
      else          begin start4 = 1; stage4 = 3'(s); inv4 = inv; end
      tick();
      start1 = 0;
      start4 = 0;
      if (accept) start_cyc[sel] = cyc;
   endtask

   task automatic drain(input int sel);
      int n;
      n = 0;
      while (((sel == 0) ? (q1.size() != 0 || busy1) : (q4.size() != 0 || busy4)) && n < 400) begin
         tick();
         n++;
      end
      check($sformatf("d%0d_drain_timeout", sel), n < 400, 1);
      check($sformatf("d%0d_queue_empty", sel), (sel == 0) ? q1.size() : q4.size(), 0);
   endtask

   task automatic wait_idle(input int sel);
      int n;
      n = 0;
      while (((sel == 0) ? busy1 : busy4) && n < 400) begin
         tick();
         n++;
      end
      check($sformatf("d%0d_idle_timeout", sel), n < 400, 1);
   endtask

   initial begin
      rst_n = 0;
      start1 = 0; stage1 = 0; inv1 = 0; tready1 = 1;
      start4 = 0; stage4 = 0; inv4 = 0; tready4 = 1;
      for (int i = 0; i < 2; i++) begin
         first_cyc[i] = -1; last_cyc[i] = 0; start_cyc[i] = 0;
         stalled[i] = 0; after_last[i] = 0; held[i] = '0;
      end
      #1;
      tick();
      tick();
      check("rst_busy1", busy1, 0);
      check("rst_tvalid1", tvalid1, 0);
      check("rst_tlast1", tlast1, 0);
      check("rst_cos1", cos1, 0);
      check("rst_sin1", sin1, 0);
      check("rst_busy4", busy4, 0);
      check("rst_tvalid4", tvalid4, 0);
      check("rst_cos4", cos4, 0);
      check("rst_sin4", sin4, 0);
      rst_n = 1;
      tick();

      // stage 1: all beats are W^0, latency and bubble-free streaming
      start_frame(0, 1, 0, 1);
      drain(0);
      check("t1_latency", first_cyc[0] - start_cyc[0], 3);
      check("t1_no_bubble", last_cyc[0] - first_cyc[0], 7);

      // full stage, forward then inverse
      start_frame(0, 4, 0, 1);
      drain(0);
      start_frame(0, 4, 1, 1);
      drain(0);

      // four lanes per beat
      start_frame(1, 3, 0, 1);
      drain(1);
      check("t4_latency", first_cyc[1] - start_cyc[1], 3);
      check("t4_no_bubble", last_cyc[1] - first_cyc[1], 1);

      // start while busy and stage/inv changes mid-frame are ignored
      start_frame(0, 2, 0, 1);
      tick();
      start_frame(0, 3, 1, 0);
      tick();
      start_frame(0, 4, 1, 0);
      drain(0);

      // out-of-range stage values never start a frame
      start_frame(0, 0, 0, 0);
      repeat (5) tick();
      check("stage0_busy", busy1, 0);
      check("stage0_tvalid", tvalid1, 0);
      start_frame(0, 5, 0, 0);
      start_frame(1, 7, 0, 0);
      repeat (5) tick();
      check("stage5_busy", busy1, 0);
      check("stage7_busy", busy4, 0);
      check("stage7_tvalid", tvalid4, 0);

      // random backpressure, back-to-back frames over every stage
      rnd = 1;
      for (int f = 0; f < 10; f++) begin
         start_frame(0, (f % 4) + 1, 1'($urandom_range(0, 1)), 1);
         wait_idle(0);
      end
      drain(0);
      for (int f = 0; f < 10; f++) begin
         start_frame(1, (f % 4) + 1, 1'($urandom_range(0, 1)), 1);
         wait_idle(1);
      end
      drain(1);
      rnd = 0;
      tick();

      // reset mid-frame drops tvalid at once and a fresh frame is intact
      start_frame(0, 4, 0, 1);
      repeat (5) tick();
      check("midrst_pre_tvalid", tvalid1, 1);
      rst_n = 0;
      #1;
      check("midrst_tvalid", tvalid1, 0);
      check("midrst_busy", busy1, 0);
      q1.delete();
      stalled[0] = 0;
      after_last[0] = 0;
      #2;
      @(posedge clk);
      #1;
      rst_n = 1;
      tick();
      start_frame(0, 4, 1, 1);
      drain(0);
      check("midrst_latency", first_cyc[0] - start_cyc[0], 3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
